// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, ALUOp values,
// FSM states, decoded instruction classes and fault codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_PASS   = 2'b11;

    localparam logic [1:0] FC_NONE         = 2'b00;
    localparam logic [1:0] FC_IMEM_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_ILLEGAL      = 2'b10;
    localparam logic [1:0] FC_DMEM_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd5
    } ctrl_state_e;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR
    } instr_class_e;

    function automatic instr_class_e classify(input logic [6:0] op);
        instr_class_e cls;
        unique case (op)
            OP_R:      cls = CLS_R;
            OP_I:      cls = CLS_I;
            OP_LOAD:   cls = CLS_LW;
            OP_STORE:  cls = CLS_SW;
            OP_BRANCH: cls = CLS_BR;
            OP_LUI:    cls = CLS_LUI;
            OP_AUIPC:  cls = CLS_AUIPC;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            default:   cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    function automatic logic [1:0] alu_op_of(input instr_class_e cls);
        logic [1:0] op;
        unique case (cls)
            CLS_BR:                     op = ALUOP_BRANCH;
            CLS_R, CLS_I:               op = ALUOP_FUNCT;
            CLS_LUI, CLS_JAL, CLS_JALR: op = ALUOP_PASS;
            default:                    op = ALUOP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter shared by the instruction-fetch and data-access handshakes;
// flags a timeout on the MEM_TIMEOUT-th consecutive cycle without ack.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q;

    // Fires in the cycle whose increment would bring the count to MEM_TIMEOUT.
    assign timeout_o = en_i && (count_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I main controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK FSM with
// req/ack memory handshakes and a sticky FAULT state. MULTICYCLE_CTRL_PERF_EN adds counters.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT     = 16,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       Opcode,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             ir_write,
    output logic             pc_write,
    output logic             alu_a_pc,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             jal,
    output logic             jalr,
    output logic [1:0]       ALUOp,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [2:0]       state_dbg
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
        $error("multicycle_controller: MEM_TIMEOUT and CNT_W must be >= 1");
    end

    ctrl_state_e  state_q, state_d;
    instr_class_e class_q, class_d, dec_class;
    logic [1:0]   fault_code_q, fault_code_d;
    logic         wait_en, timer_clr, timeout;

    assign dec_class = classify(Opcode);
    assign wait_en   = (state_q == ST_FETCH && !imem_ack) || (state_q == ST_MEM && !dmem_ack);
    assign timer_clr = (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (timer_clr),
        .en_i     (wait_en),
        .timeout_o(timeout)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d      = state_q;
        class_d      = class_q;
        fault_code_d = fault_code_q;
        unique case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_IMEM_TIMEOUT;
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                if (dec_class != CLS_NONE) begin
                    state_d = ST_EXECUTE;
                end else if (TRAP_ON_ILLEGAL) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_ILLEGAL;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXECUTE: begin
                if (class_q == CLS_BR) begin
                    state_d = ST_FETCH;
                end else if (class_q == CLS_LW || class_q == CLS_SW) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = (class_q == CLS_SW) ? ST_FETCH : ST_WRITEBACK;
                end else if (timeout) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_DMEM_TIMEOUT;
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_FAULT:     state_d = ST_FAULT;
            default:      state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            class_q      <= CLS_NONE;
            fault_code_q <= FC_NONE;
        end else begin
            // NOTE: non-blocking so every flop samples values from before the edge.
            state_q      <= state_d;
            class_q      <= class_d;
            fault_code_q <= fault_code_d;
        end
    end

    always_comb begin
        imem_req = 1'b0;
        ir_write = 1'b0;
        dmem_req = 1'b0;
        pc_write = 1'b0;
        alu_a_pc = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        jal      = 1'b0;
        jalr     = 1'b0;
        ALUOp    = ALUOP_ADD;
        unique case (state_q)
            ST_FETCH: begin
                // Reset parks the FSM in FETCH; gating keeps the request low while held.
                imem_req = rst_n;
                ir_write = rst_n && imem_ack;
            end
            ST_DECODE: begin
                pc_write = (dec_class == CLS_NONE) && !TRAP_ON_ILLEGAL;
            end
            ST_EXECUTE: begin
                ALUSrc   = class_q inside {CLS_LW, CLS_SW, CLS_I, CLS_LUI, CLS_AUIPC, CLS_JALR};
                alu_a_pc = class_q inside {CLS_AUIPC, CLS_JAL};
                ALUOp    = alu_op_of(class_q);
                Branch   = (class_q == CLS_BR);
                pc_write = (class_q == CLS_BR);
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                MemRead  = (class_q == CLS_LW);
                MemWrite = (class_q == CLS_SW);
                pc_write = (class_q == CLS_SW) && dmem_ack;
            end
            ST_WRITEBACK: begin
                RegWrite = 1'b1;
                MemtoReg = (class_q == CLS_LW);
                jal      = (class_q == CLS_JAL);
                jalr     = (class_q == CLS_JALR);
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fault_code_q;
    assign state_dbg  = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] retired_q, stall_q;

    // Neither event can occur in FAULT, so both counters freeze there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (pc_write) retired_q <= retired_q + 1'b1;
            if (wait_en)  stall_q   <= stall_q + 1'b1;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: two controller instances (trap/timeout 16 and no-trap/timeout 4)
// driven instruction by instruction against a per-cycle expectation built from the ISA rules.
module tb_multicycle_controller;

    typedef struct packed {
        logic       imem_req, dmem_req, ir_write, pc_write, alu_a_pc, alu_src, mem_to_reg;
        logic       reg_write, mem_read, mem_write, branch, jal, jalr;
        logic [1:0] alu_op;
        logic       fault;
        logic [1:0] fault_code;
        logic [2:0] state;
    } ctl_t;

    localparam logic [6:0] ADD   = 7'b0110011;
    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BAD   = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode   [2];
    logic        imem_ack [2];
    logic        dmem_ack [2];
    logic [20:0] obs      [2];
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] ret_cnt  [2];
    logic [31:0] stl_cnt  [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ret   [2];
    int exp_stall [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       imem_req, dmem_req, ir_write, pc_write, alu_a_pc, alu_src, mem_to_reg;
        logic       reg_write, mem_read, mem_write, branch, jal, jalr, fault;
        logic [1:0] alu_op, fault_code;
        logic [2:0] state_dbg;

        multicycle_controller #(
            .MEM_TIMEOUT    (g == 0 ? 16 : 4),
            .TRAP_ON_ILLEGAL(g == 0),
            .CNT_W          (32)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .Opcode     (opcode[g]),
            .imem_req   (imem_req),
            .imem_ack   (imem_ack[g]),
            .dmem_req   (dmem_req),
            .dmem_ack   (dmem_ack[g]),
            .ir_write   (ir_write),
            .pc_write   (pc_write),
            .alu_a_pc   (alu_a_pc),
            .ALUSrc     (alu_src),
            .MemtoReg   (mem_to_reg),
            .RegWrite   (reg_write),
            .MemRead    (mem_read),
            .MemWrite   (mem_write),
            .Branch     (branch),
            .jal        (jal),
            .jalr       (jalr),
            .ALUOp      (alu_op),
            .fault      (fault),
            .fault_code (fault_code),
            .state_dbg  (state_dbg)
`ifdef MULTICYCLE_CTRL_PERF_EN
            ,
            .retired_cnt(ret_cnt[g]),
            .stall_cnt  (stl_cnt[g])
`endif
        );

        assign obs[g] = {imem_req, dmem_req, ir_write, pc_write, alu_a_pc, alu_src, mem_to_reg,
                         reg_write, mem_read, mem_write, branch, jal, jalr, alu_op, fault,
                         fault_code, state_dbg};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic stray(input int g);
        imem_ack[g] = 1'($urandom);
        dmem_ack[g] = 1'($urandom);
    endtask

    // One clock period: inputs already applied at posedge+1, outputs sampled at negedge.
    task automatic cyc(input int g, input ctl_t e, input string tag);
        @(negedge clk);
        check(tag, {11'd0, obs[g]}, {11'd0, e});
        if (e.pc_write) exp_ret[g]++;
        if ((e.imem_req && !imem_ack[g]) || (e.dmem_req && !dmem_ack[g])) exp_stall[g]++;
        @(posedge clk);
        #1;
    endtask

    task automatic perf_chk(input int g);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("retired_cnt", ret_cnt[g], 32'(exp_ret[g]));
        check("stall_cnt", stl_cnt[g], 32'(exp_stall[g]));
`endif
    endtask

    task automatic do_reset(input int g);
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {11'd0, obs[g]}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            exp_ret[i]   = 0;
            exp_stall[i] = 0;
        end
        perf_chk(g);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            imem_ack[i] = 1'b0;
            dmem_ack[i] = 1'b0;
        end
        rst_n = 1'b1;
    endtask

    task automatic enter_fault(input int g, input logic [1:0] code);
        ctl_t e = '0;
        e.fault      = 1'b1;
        e.fault_code = code;
        e.state      = 3'd5;
        for (int k = 0; k < 3; k++) begin
            stray(g);
            opcode[g] = 7'($urandom);
            cyc(g, e, "fault_hold");
        end
        perf_chk(g);
        do_reset(g);
    endtask

    // wi/wd: wait cycles before imem/dmem ack; abort_at >= 0 pulls rst_n in that MEM wait cycle.
    task automatic run_instr(input int g, input logic [6:0] op, input int wi, input int wd,
                             input int abort_at);
        ctl_t e;
        int   tmo  = (g == 0) ? 16 : 4;
        bit   trap = (g == 0);
        bit   is_r = (op == ADD),  is_i = (op == ADDI), ld = (op == LW), st = (op == SW);
        bit   br = (op == BEQ), lui = (op == LUI), auipc = (op == AUIPC);
        bit   is_jal = (op == JAL), is_jalr = (op == JALR);
        bit   legal = is_r | is_i | ld | st | br | lui | auipc | is_jal | is_jalr;

        for (int k = 0; k <= wi; k++) begin
            if (k == tmo) begin
                enter_fault(g, 2'b01);
                return;
            end
            stray(g);
            imem_ack[g] = (k == wi);
            opcode[g]   = 7'($urandom);
            e = '0;
            e.imem_req = 1'b1;
            e.ir_write = (k == wi);
            cyc(g, e, "fetch");
        end

        stray(g);
        opcode[g] = op;
        e = '0;
        e.state    = 3'd1;
        e.pc_write = !legal && !trap;
        cyc(g, e, "decode");
        if (!legal) begin
            if (trap) enter_fault(g, 2'b10);
            else perf_chk(g);
            return;
        end

        stray(g);
        e = '0;
        e.state    = 3'd2;
        e.alu_src  = ld | st | is_i | lui | auipc | is_jalr;
        e.alu_a_pc = auipc | is_jal;
        e.alu_op   = (ld | st | auipc) ? 2'b00 : br ? 2'b01 : (is_r | is_i) ? 2'b10 : 2'b11;
        e.branch   = br;
        e.pc_write = br;
        cyc(g, e, "execute");
        if (br) begin
            perf_chk(g);
            return;
        end

        if (ld | st) begin
            for (int k = 0; k <= wd; k++) begin
                if (k == tmo) begin
                    enter_fault(g, 2'b11);
                    return;
                end
                stray(g);
                dmem_ack[g] = (k == wd) && (k != abort_at);
                e = '0;
                e.state     = 3'd3;
                e.dmem_req  = 1'b1;
                e.mem_read  = ld;
                e.mem_write = st;
                e.pc_write  = st && (k == wd);
                if (k == abort_at) begin
                    #1;
                    check("mem_before_reset", {11'd0, obs[g]}, {11'd0, e});
                    do_reset(g);
                    return;
                end
                cyc(g, e, "mem");
            end
            if (st) begin
                perf_chk(g);
                return;
            end
        end

        stray(g);
        e = '0;
        e.state      = 3'd4;
        e.reg_write  = 1'b1;
        e.mem_to_reg = ld;
        e.jal        = is_jal;
        e.jalr       = is_jalr;
        e.pc_write   = 1'b1;
        cyc(g, e, "writeback");
        perf_chk(g);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] legal_ops [9];
        logic [6:0] op;
        int         wi, wd;

        legal_ops = '{ADD, ADDI, LW, SW, BEQ, LUI, AUIPC, JAL, JALR};
        for (int i = 0; i < 2; i++) begin
            opcode[i]   = '0;
            imem_ack[i] = 1'b0;
            dmem_ack[i] = 1'b0;
        end
        #3;
        do_reset(0);

        run_instr(0, ADD,   0, 0, -1);
        run_instr(0, LW,    0, 3, -1);
        run_instr(0, BEQ,   0, 0, -1);
        run_instr(0, JAL,   0, 0, -1);
        run_instr(0, AUIPC, 0, 0, -1);
        run_instr(0, SW,    1, 2, -1);
        run_instr(0, ADDI,  2, 0, -1);
        run_instr(0, LUI,   0, 0, -1);
        run_instr(0, JALR,  0, 0, -1);
        run_instr(0, LW,    0, 15, -1);
        run_instr(0, ADD,   15, 0, -1);
        run_instr(0, SW,    0, 5, 2);
        run_instr(0, ADD,   0, 0, -1);
        run_instr(0, BAD,   0, 0, -1);
        run_instr(0, ADD,   30, 0, -1);
        run_instr(0, LW,    0, 16, -1);

        do_reset(1);
        run_instr(1, BAD,   0, 0, -1);
        run_instr(1, ADD,   0, 0, -1);
        run_instr(1, SW,    0, 3, -1);
        run_instr(1, LW,    0, 4, -1);
        run_instr(1, ADD,   4, 0, -1);

        for (int g = 0; g < 2; g++) begin
            do_reset(g);
            repeat (150) begin
                op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
                wi = ($urandom_range(0, 24) == 0) ? 20 : $urandom_range(0, 3);
                wd = ($urandom_range(0, 24) == 0) ? 20 : $urandom_range(0, 3);
                run_instr(g, op, wi, wd, ($urandom_range(0, 29) == 0) ? 0 : -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle main controller for the RV32I core; replaces the single-cycle opcode decoder with an FSM that sequences fetch, decode, execute, memory and writeback.
- Handshakes with instruction and data memories (req/ack) of arbitrary latency, with a bounded wait timeout.
- Decodes AUIPC in addition to R/I/LW/SW/BR/LUI/JAL/JALR.
- Traps illegal opcodes and memory timeouts into a sticky fault state.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles a memory request may wait for ack before fault; must be >= 1.
- TRAP_ON_ILLEGAL, 1: 1 = illegal opcode enters FAULT; 0 = illegal opcode retires as NOP.
- CNT_W, 32: width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Opcode  in  7  instruction[6:0] from the instruction register; stable from DECODE until return to FETCH.
- imem_req / imem_ack  out / in  1 / 1  instruction fetch handshake.
- dmem_req / dmem_ack  out / in  1 / 1  data access handshake.
- ir_write  out  1  one-cycle pulse that loads the instruction register.
- pc_write  out  1  one-cycle pulse that updates the PC; the datapath selects PC+4, branch or jump target.
- alu_a_pc  out  1  ALU operand A = PC (AUIPC, JAL).
- ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, jal, jalr  out  1 each  datapath controls, state-qualified.
- ALUOp  out  2  00 = add (LW/SW/AUIPC); 01 = branch; 10 = R/I funct decode; 11 = LUI/JAL/JALR.
- fault  out  1  sticky fault flag.
- fault_code  out  2  01 = imem timeout; 10 = illegal opcode; 11 = dmem timeout.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset, asynchronous assert:
  - state = FETCH; wait counter = 0; decoded class register cleared.
  - All outputs 0, including fault and fault_code.
  - Applies mid-transaction: any outstanding req drops immediately.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, FAULT.
- FETCH:
  - imem_req held high until imem_ack.
  - Ack in the same cycle req is first raised is accepted (zero-wait).
  - On ack: ir_write = 1 in that cycle, next state DECODE.
  - Wait counter increments each cycle without ack. When the counter reaches MEM_TIMEOUT: FAULT, code 01.
- DECODE (1 cycle):
  - Classify Opcode and register the class.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111.
  - Illegal with TRAP_ON_ILLEGAL = 1: FAULT, code 10.
  - Illegal with TRAP_ON_ILLEGAL = 0: pc_write = 1, back to FETCH.
- EXECUTE (1 cycle):
  - ALUSrc = 1 for LW, SW, I-type, LUI, AUIPC, JALR.
  - alu_a_pc = 1 for AUIPC and JAL.
  - ALUOp per the class table above.
  - BR: Branch = 1 and pc_write = 1, then FETCH.
  - LW/SW: next state MEM. All other classes: next state WRITEBACK.
- MEM:
  - dmem_req held, with MemRead (LW) or MemWrite (SW) held alongside, until dmem_ack.
  - On ack, SW: pc_write = 1, then FETCH.
  - On ack, LW: WRITEBACK.
  - Timeout rule as in FETCH: FAULT, code 11.
- WRITEBACK (1 cycle):
  - RegWrite = 1; MemtoReg = 1 only for LW; jal/jalr asserted per class; pc_write = 1; then FETCH.
- FAULT: absorbing; only rst_n exits. All control outputs 0; no requests issued.
- Wait counter clears on every state change. Width is clog2(MEM_TIMEOUT + 1).
- Ack with no request outstanding is ignored.
- Latency with zero-wait memories: BR 3 cycles; R/I/LUI/AUIPC/JAL/JALR/SW 4 cycles; LW 5 cycles. Each wait cycle adds one.
- Exactly one pc_write pulse per retired instruction. No pc_write on fault.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- With the macro defined, two extra outputs:
  - retired_cnt (CNT_W): +1 on each pc_write.
  - stall_cnt (CNT_W): +1 each cycle a req is high without ack.
  - Both wrap modulo 2^CNT_W, reset to 0, and freeze in FAULT.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode localparams;
  - ALUOp encodings;
  - state enum (3-bit);
  - instruction-class enum;
  - fault_code constants.
- One sub-module, mem_wait_timer: counter with clear, enable and timeout output, parametrised by MEM_TIMEOUT. It is instantiated once and shared by FETCH and MEM.

Test Plan:
1. Zero-wait: add (0110011) → ir_write in cycle 1; RegWrite = 1, ALUOp = 10 in cycle 4; one pc_write; back in FETCH.
2. LW with dmem_ack delayed 3 cycles → MemRead and dmem_req high 4 cycles; WRITEBACK with MemtoReg = 1; total 8 cycles.
3. imem_ack never asserted, MEM_TIMEOUT = 16 → fault = 1, code 01 after 16 cycles; outputs 0 thereafter; rst_n low then high restarts in FETCH.
4. Opcode 7'b1111111:
   - TRAP_ON_ILLEGAL = 1 → FAULT, code 10.
   - TRAP_ON_ILLEGAL = 0 → pc_write pulse, no RegWrite, next FETCH.
5. BR then JAL then AUIPC:
   - BR: Branch and pc_write in cycle 3.
   - JAL: jal, RegWrite and alu_a_pc with ALUOp = 11.
   - AUIPC: alu_a_pc = 1, ALUSrc = 1, ALUOp = 00.
6. rst_n asserted during MEM wait of an SW → dmem_req and MemWrite drop asynchronously; no pc_write; with PERF_EN, counters read 0.
